axil_cmd_master: RTL
====================

Name: axil_cmd_master

Overview:
- Synthesizable AXI4-Lite initiator that turns a simple valid/ready command stream into single AXI4-Lite write or read transactions.
- Returns each transaction's response on a valid/ready response stream.
- Sits upstream of the axilite crossbar, next to or in place of the PS master. The on-chip RF init/config sequencer uses it to program rf_ctrl (0x0000_0000–0x000F_FFFF) and regs (0x0010_0000–0x0010_FFFF).
- One outstanding transaction at a time.

Parameters:
- ADDR_W, 32, AXI4-Lite address width.
- DATA_W, 32, AXI4-Lite data width (32 only; STRB_W = DATA_W/8).
- TIMEOUT_CYC, 1024, cycles from command accept before the timeout event fires.
- CNT_W, 16, width of the saturating transaction/error counters.

Ports:
- axilite_clk  in  1  clock.
- axilite_rstb  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  STRB_W  write strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_is_read  out  1  response belongs to a read.
- rsp_rdata  out  DATA_W  read data (0 for writes).
- rsp_resp  out  2  BRESP/RRESP.
- m_axil_aw*  out/in  awaddr[ADDR_W], awprot[3], awvalid, awready(in).
- m_axil_w*  out/in  wdata[DATA_W], wstrb[STRB_W], wvalid, wready(in).
- m_axil_b*  in/out  bresp[2](in), bvalid(in), bready(out).
- m_axil_ar*  out/in  araddr[ADDR_W], arprot[3], arvalid, arready(in).
- m_axil_r*  in/out  rdata[DATA_W](in), rresp[2](in), rvalid(in), rready(out).
- timeout_pulse  out  1  one-cycle pulse when TIMEOUT_CYC is reached.
- timeout_flag  out  1  sticky timeout; cleared only by reset.
- wr_cnt, rd_cnt, err_cnt  out  CNT_W  saturating counts of completed writes, completed reads, and non-OKAY responses.

Behaviour:
- Reset: async assert on axilite_rstb=0. While reset is asserted and after release:
  - all valid/ready outputs are 0 except cmd_ready=1;
  - addresses, data, strobes, rsp_* and counters are 0;
  - timeout_flag is 0; state is IDLE.
- Reset mid-transaction drops all valids immediately. The system resets the slave side together with this block.
- awprot/arprot are constant 3'b000.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register addr/data/strb/type, clear the timeout counter, and go to WR_REQ or RD_REQ.
- Latency: command accepted in cycle N → awvalid+wvalid (or arvalid) high from N+1.
- WR_REQ: awvalid and wvalid are independent. Each drops the cycle after its own handshake and is never withdrawn before its handshake.
  - AW and W may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, capture bresp and go to RSP.
- RD_REQ: arvalid=1 until arready, then go to RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata/rresp and go to RSP.
- RSP: rsp_valid=1, with outputs stable until rsp_ready; then go to IDLE.
- Back-to-back throughput: with zero-wait slave, write = B handshake at N+2, rsp_valid at N+3.
- Counters update in the cycle of the B/R handshake:
  - wr_cnt/rd_cnt +1 per completed transaction;
  - err_cnt +1 if resp≠2'b00;
  - all saturate at 2^CNT_W−1 (no wrap).
- Timeout:
  - the counter runs from accept while state∉{IDLE,RSP};
  - on reaching TIMEOUT_CYC: timeout_pulse for 1 cycle, timeout_flag set;
  - the counter then holds; at most one pulse per transaction;
  - the transaction is NOT aborted; valids stay asserted per AXI rules.
- rsp_ready held high in RSP → IDLE next cycle; cmd_ready returns one cycle after the response handshake.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - state enum typedef;
  - cmd_t struct {write, addr, wdata, wstrb};
  - rsp_t struct {is_read, rdata, resp}.
- Sub-module sat_counter (width param, inc, count). Instantiated three times for wr_cnt/rd_cnt/err_cnt.

Test Plan:
- Write 0x0000_0000←0x10, then read back via the crossbar + reg_map → rsp_resp=00, rsp_rdata=0x10, wr_cnt=1, rd_cnt=1, err_cnt=0.
- Write 0x0010_0000←0x40, with the slave delaying wready 5 cycles after awready → awvalid drops after its handshake, wvalid held until wready, single rsp with resp=00.
- Write 0x8000_0000←0x10 (unmapped) → rsp_resp=2'b11 (DECERR from crossbar), err_cnt=1, wr_cnt=1.
- Stub slave never asserts arready, TIMEOUT_CYC=16 → timeout_pulse exactly once at accept+16, timeout_flag=1, arvalid stays 1. Then arready+rvalid with data 0xA5 → normal rsp.
- Hold rsp_ready=0 for 10 cycles after rsp_valid → rsp_valid/rsp_rdata stable, cmd_ready=0 throughout, new cmd accepted the cycle after the handshake.
- Assert axilite_rstb=0 while in WR_REQ → awvalid/wvalid go 0 asynchronously, counters and timeout_flag 0, cmd_ready=1 after release.

Source files
------------

// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes, FSM states and command/response records
// for the AXI4-Lite command master.
package axil_pkg;

   localparam int AXIL_ADDR_W = 32;
   localparam int AXIL_DATA_W = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_RESP,
      RSP
   } state_t;

   typedef struct packed {
      logic                       write;
      logic [AXIL_ADDR_W-1:0]     addr;
      logic [AXIL_DATA_W-1:0]     wdata;
      logic [AXIL_DATA_W/8-1:0]   wstrb;
   } cmd_t;

   typedef struct packed {
      logic                       is_read;
      logic [AXIL_DATA_W-1:0]     rdata;
      logic [1:0]                 resp;
   } rsp_t;

endpackage

// File: rtl/axil_cmd_master_sat_counter.sv
// sat_counter: counter that increments on i_inc and sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (i_inc && r_count != '1)
         r_count <= r_count + 1'b1;
   end

   assign o_count = r_count;

endmodule

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns a valid/ready command stream into single AXI4-Lite reads/writes,
// one outstanding at a time, and returns each response on a valid/ready stream.
module axil_cmd_master
   import axil_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic                axilite_clk,
   input  logic                axilite_rstb,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_is_read,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic [ADDR_W-1:0]   m_axil_awaddr,
   output logic [2:0]          m_axil_awprot,
   output logic                m_axil_awvalid,
   input  logic                m_axil_awready,
   output logic [DATA_W-1:0]   m_axil_wdata,
   output logic [DATA_W/8-1:0] m_axil_wstrb,
   output logic                m_axil_wvalid,
   input  logic                m_axil_wready,
   input  logic [1:0]          m_axil_bresp,
   input  logic                m_axil_bvalid,
   output logic                m_axil_bready,
   output logic [ADDR_W-1:0]   m_axil_araddr,
   output logic [2:0]          m_axil_arprot,
   output logic                m_axil_arvalid,
   input  logic                m_axil_arready,
   input  logic [DATA_W-1:0]   m_axil_rdata,
   input  logic [1:0]          m_axil_rresp,
   input  logic                m_axil_rvalid,
   output logic                m_axil_rready,
   output logic                timeout_pulse,
   output logic                timeout_flag,
   output logic [CNT_W-1:0]    wr_cnt,
   output logic [CNT_W-1:0]    rd_cnt,
   output logic [CNT_W-1:0]    err_cnt
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t        r_state, w_next;
   cmd_t          r_cmd;
   rsp_t          r_rsp;
   logic          r_aw_done, r_w_done, r_tflag;
   logic [TW-1:0] r_tcnt;
   logic          w_accept, w_aw_hs, w_w_hs, w_b_hs, w_r_hs, w_busy, w_err_inc;

   always_comb begin
      w_next         = r_state;
      cmd_ready      = 1'b0;
      m_axil_awvalid = 1'b0;
      m_axil_wvalid  = 1'b0;
      m_axil_bready  = 1'b0;
      m_axil_arvalid = 1'b0;
      m_axil_rready  = 1'b0;
      rsp_valid      = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) w_next = cmd_write ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            m_axil_awvalid = !r_aw_done;
            m_axil_wvalid  = !r_w_done;
            if ((r_aw_done || m_axil_awready) && (r_w_done || m_axil_wready)) w_next = WR_RESP;
         end
         WR_RESP: begin
            m_axil_bready = 1'b1;
            if (m_axil_bvalid) w_next = RSP;
         end
         RD_REQ: begin
            m_axil_arvalid = 1'b1;
            if (m_axil_arready) w_next = RD_RESP;
         end
         RD_RESP: begin
            m_axil_rready = 1'b1;
            if (m_axil_rvalid) w_next = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_accept  = cmd_valid && cmd_ready;
   assign w_aw_hs   = m_axil_awvalid && m_axil_awready;
   assign w_w_hs    = m_axil_wvalid && m_axil_wready;
   assign w_b_hs    = m_axil_bvalid && m_axil_bready;
   assign w_r_hs    = m_axil_rvalid && m_axil_rready;
   assign w_busy    = r_state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
   assign w_err_inc = (w_b_hs && m_axil_bresp != RESP_OKAY) || (w_r_hs && m_axil_rresp != RESP_OKAY);

   always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
      if (!axilite_rstb) begin
         r_state   <= IDLE;
         r_cmd     <= '0;
         r_rsp     <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_tcnt    <= '0;
         r_tflag   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_cmd.write <= cmd_write;
            r_cmd.addr  <= AXIL_ADDR_W'(cmd_addr);
            r_cmd.wdata <= cmd_wdata;
            r_cmd.wstrb <= cmd_wstrb;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
         end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs) r_w_done <= 1'b1;
         end
         if (w_b_hs || w_r_hs) begin
            r_rsp.is_read <= !r_cmd.write;
            r_rsp.rdata   <= w_r_hs ? m_axil_rdata : '0;
            r_rsp.resp    <= w_r_hs ? m_axil_rresp : m_axil_bresp;
         end
         // timer parks at TIMEOUT_CYC so the pulse can fire only once per transaction
         if (w_accept)
            r_tcnt <= '0;
         else if (w_busy && r_tcnt != TW'(TIMEOUT_CYC))
            r_tcnt <= r_tcnt + 1'b1;
         if (timeout_pulse) r_tflag <= 1'b1;
      end
   end

   assign timeout_pulse = w_busy && r_tcnt == TW'(TIMEOUT_CYC - 1);
   assign timeout_flag  = r_tflag;

   assign m_axil_awaddr = r_cmd.addr[ADDR_W-1:0];
   assign m_axil_araddr = r_cmd.addr[ADDR_W-1:0];
   assign m_axil_awprot = 3'b000;
   assign m_axil_arprot = 3'b000;
   assign m_axil_wdata  = r_cmd.wdata;
   assign m_axil_wstrb  = r_cmd.wstrb;

   assign rsp_is_read = r_rsp.is_read;
   assign rsp_rdata   = r_rsp.rdata;
   assign rsp_resp    = r_rsp.resp;

   sat_counter #(.W(CNT_W)) u_wr_cnt (
      .clk     (axilite_clk),
      .rst_n   (axilite_rstb),
      .i_inc   (w_b_hs),
      .o_count (wr_cnt)
   );

   sat_counter #(.W(CNT_W)) u_rd_cnt (
      .clk     (axilite_clk),
      .rst_n   (axilite_rstb),
      .i_inc   (w_r_hs),
      .o_count (rd_cnt)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk     (axilite_clk),
      .rst_n   (axilite_rstb),
      .i_inc   (w_err_inc),
      .o_count (err_cnt)
   );

endmodule
